multi_user_locker: RTL and testbench

Parametrised successor to the two-bit-user digital locker. It adds N users, a configurable password width and attempt limit, per-user failure counters, an explicit unlocked session with timeout, and a global alarm lockout. It sits between the keypad/user-select front end and the lock actuator plus alarm driver.

---
 rtl/multi_user_locker_pkg.sv | 23 ++
 rtl/multi_user_locker_if.sv | 25 ++
 rtl/multi_user_locker_timer.sv | 35 +++
 rtl/multi_user_locker.sv | 211 +++++++++++++++++++++
 tb/tb_multi_user_locker.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_user_locker_pkg.sv
// Shared types and helpers for the multi-user locker.
// Optional build macro used by the design: LOCKER_LOCKOUT_TIMER_EN
// (timed exit from the alarm state instead of latching until reset).
package locker_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    ALARM = 2'd2
  } locker_state_t;

  // Width of a counter that must hold every value 0..max without wrapping.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

  // Default password layout: DEFAULT_PW is NUM_USERS*PW_WIDTH bits packed,
  // user k occupies bits [k*PW_WIDTH +: PW_WIDTH]. With 4 users of 12 bits,
  // 48'h0CC_0BB_0AA_000 gives user0=000, user1=0AA, user2=0BB, user3=0CC.
  localparam logic [47:0] LOCKER_DEFAULT_PW = 48'h0CC_0BB_0AA_000;

endpackage

// File: rtl/multi_user_locker_if.sv
// Keypad/user-select front end <-> locker connection.
// The master modport is the front end, the slave modport is the locker.
interface multi_user_locker_if #(
  parameter int U_W      = 2,
  parameter int PW_WIDTH = 12,
  parameter int CNT_W    = 2
);
  logic                Enter;
  logic                SET_MODE;
  logic [U_W-1:0]      User;
  logic [PW_WIDTH-1:0] InputPassword;
  logic                Access;
  logic                Alarm;
  logic [CNT_W-1:0]    Count;

  modport master (
    output Enter, SET_MODE, User, InputPassword,
    input  Access, Alarm, Count
  );

  modport slave (
    input  Enter, SET_MODE, User, InputPassword,
    output Access, Alarm, Count
  );
endinterface

// File: rtl/multi_user_locker_timer.sv
// Load/count/expire down-counter. A load sets the remaining count; while
// enabled it counts down to zero and then holds, flagging expiry.
module locker_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load has priority over counting; stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/multi_user_locker.sv
// Multi-user digital locker: per-user passwords and failure counters,
// timed unlocked session, global alarm lockout.
// Optional build macro: LOCKER_LOCKOUT_TIMER_EN -- when defined the alarm
// releases itself after LOCKOUT_CYCLES; otherwise it latches until reset.
module multi_user_locker
  import locker_pkg::*;
#(
  parameter int                         NUM_USERS      = 4,
  parameter int                         PW_WIDTH       = 12,
  parameter int                         MAX_ATTEMPTS   = 3,
  parameter logic [NUM_USERS*PW_WIDTH-1:0] DEFAULT_PW  = LOCKER_DEFAULT_PW,
  parameter int                         SESSION_CYCLES = 64,
  parameter int                         LOCKOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_user_locker_if.slave    bus
);
  localparam int U_W   = $clog2(NUM_USERS);
  localparam int CNT_W = cnt_w(MAX_ATTEMPTS);
  localparam int SES_W = cnt_w(SESSION_CYCLES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ATTEMPTS);
  localparam logic [U_W:0]     NUM_U   = (U_W+1)'(NUM_USERS);

  // Elaboration-time parameter sanity checks.
  if (NUM_USERS < 2) begin : g_bad_users
    $error("NUM_USERS must be at least 2");
  end
  if (MAX_ATTEMPTS < 1) begin : g_bad_attempts
    $error("MAX_ATTEMPTS must be at least 1");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
    $error("LOCKOUT_CYCLES must be at least 1");
  end

  locker_state_t state_q, state_d;
  logic [U_W-1:0] sess_user_q, sess_user_d;
  logic           enter_q;

  logic [CNT_W-1:0]    fail_vec [NUM_USERS];
  logic [PW_WIDTH-1:0] pw_vec   [NUM_USERS];

  logic                attempt;
  logic                user_valid;
  logic [CNT_W-1:0]    cur_fail;
  logic [PW_WIDTH-1:0] cur_pw;
  logic                match;
  logic                sess_expired;

  logic           sess_load;
  logic           fail_inc;
  logic           fail_clr;
  logic [U_W-1:0] fail_clr_idx;
  logic           pw_we;
  logic           do_eval;

`ifdef LOCKER_LOCKOUT_TIMER_EN
  localparam int LCK_W = cnt_w(LOCKOUT_CYCLES);
  logic [U_W-1:0] alarm_user_q, alarm_user_d;
  logic           lock_load;
  logic           lock_expired;
`endif

  // Only the rising edge of the level Enter input is an attempt.
  assign attempt    = bus.Enter & ~enter_q;
  assign user_valid = ({1'b0, bus.User} < NUM_U);
  assign cur_fail   = user_valid ? fail_vec[bus.User] : '0;
  assign cur_pw     = user_valid ? pw_vec[bus.User]   : '0;
  assign match      = user_valid && (bus.InputPassword == cur_pw);

  // Next state and per-cycle storage commands.
  always_comb begin
    state_d      = state_q;
    sess_user_d  = sess_user_q;
    sess_load    = 1'b0;
    fail_inc     = 1'b0;
    fail_clr     = 1'b0;
    fail_clr_idx = bus.User;
    pw_we        = 1'b0;
    do_eval      = 1'b0;
`ifdef LOCKER_LOCKOUT_TIMER_EN
    lock_load    = 1'b0;
    alarm_user_d = alarm_user_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (attempt) do_eval = 1'b1;
      end
      OPEN: begin
        if (attempt) begin
          if (bus.SET_MODE && (bus.User == sess_user_q)) begin
            pw_we    = 1'b1;
            fail_clr = 1'b1;
            state_d  = IDLE;
          end else begin
            // Closes the session, then judged like an idle attempt.
            state_d = IDLE;
            do_eval = 1'b1;
          end
        end else if (sess_expired) begin
          state_d = IDLE;
        end
      end
      ALARM: begin
`ifdef LOCKER_LOCKOUT_TIMER_EN
        if (lock_expired) begin
          state_d      = IDLE;
          fail_clr     = 1'b1;
          fail_clr_idx = alarm_user_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (do_eval) begin
      if (!bus.SET_MODE && match) begin
        state_d     = OPEN;
        sess_user_d = bus.User;
        fail_clr    = 1'b1;
        sess_load   = 1'b1;
      end else if (user_valid) begin
        // A programming request without an open session also lands here.
        fail_inc = 1'b1;
        if (cur_fail >= (MAX_CNT - 1'b1)) begin
          state_d = ALARM;
`ifdef LOCKER_LOCKOUT_TIMER_EN
          lock_load    = 1'b1;
          alarm_user_d = bus.User;
`endif
        end
      end
    end
  end

  // Controller state, session owner and Enter edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sess_user_q <= '0;
      enter_q     <= 1'b0;
`ifdef LOCKER_LOCKOUT_TIMER_EN
      alarm_user_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sess_user_q <= sess_user_d;
      enter_q     <= bus.Enter;
`ifdef LOCKER_LOCKOUT_TIMER_EN
      alarm_user_q <= alarm_user_d;
`endif
    end
  end

  // Per-user password and saturating failure counter.
  for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_user
    logic [CNT_W-1:0]    fail_q;
    logic [PW_WIDTH-1:0] pw_q;

    // Counter clear wins over increment; password written only by its owner.
    always_ff @(posedge clk) begin
      if (reset) begin
        fail_q <= '0;
        pw_q   <= DEFAULT_PW[gi*PW_WIDTH +: PW_WIDTH];
      end else begin
        if (fail_clr && (fail_clr_idx == U_W'(gi))) begin
          fail_q <= '0;
        end else if (fail_inc && (bus.User == U_W'(gi)) && (fail_q != MAX_CNT)) begin
          fail_q <= fail_q + 1'b1;
        end
        if (pw_we && (bus.User == U_W'(gi))) begin
          pw_q <= bus.InputPassword;
        end
      end
    end

    assign fail_vec[gi] = fail_q;
    assign pw_vec[gi]   = pw_q;
  end

  // Session timer: loaded with SESSION_CYCLES-1 on open, so the session
  // lasts exactly SESSION_CYCLES cycles. Zero disables the timeout.
  if (SESSION_CYCLES > 0) begin : g_sess
    locker_timer #(.WIDTH(SES_W)) u_sess_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (sess_load),
      .load_val_i (SES_W'(SESSION_CYCLES - 1)),
      .en_i       (state_q == OPEN),
      .expired_o  (sess_expired)
    );
  end else begin : g_no_sess
    assign sess_expired = 1'b0;
  end

`ifdef LOCKER_LOCKOUT_TIMER_EN
  // Lockout timer: started only on entry into ALARM.
  locker_timer #(.WIDTH(LCK_W)) u_lock_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (lock_load),
    .load_val_i (LCK_W'(LOCKOUT_CYCLES - 1)),
    .en_i       (state_q == ALARM),
    .expired_o  (lock_expired)
  );
`endif

  assign bus.Access = (state_q == OPEN);
  assign bus.Alarm  = (state_q == ALARM);
  assign bus.Count  = cur_fail;
endmodule

// File: tb/tb_multi_user_locker.sv
// Directed testbench for multi_user_locker (4 users, 12-bit passwords,
// 3 attempts, 64-cycle session, 16-cycle lockout when enabled).
module tb_multi_user_locker;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  multi_user_locker_if #(.U_W(2), .PW_WIDTH(12), .CNT_W(2)) bus ();

  multi_user_locker #(
    .NUM_USERS      (4),
    .PW_WIDTH       (12),
    .MAX_ATTEMPTS   (3),
    .DEFAULT_PW     (48'h0CC_0BB_0AA_000),
    .SESSION_CYCLES (64),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.Enter = 1'b0;
    bus.SET_MODE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One attempt: Enter high across exactly one rising edge; outputs are
  // then observed on the following falling edge.
  task automatic attempt(input logic [1:0] u, input logic [11:0] p, input logic s);
    @(negedge clk);
    bus.User = u;
    bus.InputPassword = p;
    bus.SET_MODE = s;
    bus.Enter = 1'b1;
    @(negedge clk);
    bus.Enter = 1'b0;
    bus.SET_MODE = 1'b0;
    $display("txn user=%0d pw=%h set=%0b -> Access=%0b Alarm=%0b Count=%0d",
             u, p, s, bus.Access, bus.Alarm, bus.Count);
  endtask

  task automatic test_reset();
    do_reset();
    bus.User = 2'd1;
    #1;
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL reset_access: got %0b expected 0", bus.Access); end
    checks++; if (bus.Alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %0b expected 0", bus.Alarm); end
    checks++; if (bus.Count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.Count); end
  endtask

  task automatic test_alarm();
    do_reset();
    attempt(2'd1, 12'h123, 1'b0);
    checks++; if (bus.Count !== 2'd1) begin errors++; $display("FAIL alarm_cnt1: got %0d expected 1", bus.Count); end
    checks++; if (bus.Alarm !== 1'b0) begin errors++; $display("FAIL alarm_early1: got %0b expected 0", bus.Alarm); end
    attempt(2'd1, 12'h456, 1'b0);
    checks++; if (bus.Count !== 2'd2) begin errors++; $display("FAIL alarm_cnt2: got %0d expected 2", bus.Count); end
    checks++; if (bus.Alarm !== 1'b0) begin errors++; $display("FAIL alarm_early2: got %0b expected 0", bus.Alarm); end
    attempt(2'd1, 12'h789, 1'b0);
    checks++; if (bus.Count !== 2'd3) begin errors++; $display("FAIL alarm_cnt3: got %0d expected 3", bus.Count); end
    checks++; if (bus.Alarm !== 1'b1) begin errors++; $display("FAIL alarm_set: got %0b expected 1", bus.Alarm); end
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL alarm_access: got %0b expected 0", bus.Access); end
    attempt(2'd1, 12'h0AA, 1'b0);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL alarm_ignore_access: got %0b expected 0", bus.Access); end
    checks++; if (bus.Count !== 2'd3) begin errors++; $display("FAIL alarm_ignore_count: got %0d expected 3", bus.Count); end
  endtask

  task automatic test_program();
    do_reset();
    attempt(2'd1, 12'h0AA, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL prog_open: got %0b expected 1", bus.Access); end
    checks++; if (bus.Count !== 2'd0) begin errors++; $display("FAIL prog_open_count: got %0d expected 0", bus.Count); end
    attempt(2'd1, 12'h555, 1'b1);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL prog_close: got %0b expected 0", bus.Access); end
    attempt(2'd1, 12'h0AA, 1'b0);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL prog_old_pw: got %0b expected 0", bus.Access); end
    checks++; if (bus.Count !== 2'd1) begin errors++; $display("FAIL prog_old_count: got %0d expected 1", bus.Count); end
    attempt(2'd1, 12'h555, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL prog_new_pw: got %0b expected 1", bus.Access); end
    checks++; if (bus.Count !== 2'd0) begin errors++; $display("FAIL prog_new_count: got %0d expected 0", bus.Count); end
  endtask

  task automatic test_set_no_session();
    do_reset();
    attempt(2'd2, 12'h777, 1'b1);
    checks++; if (bus.Count !== 2'd1) begin errors++; $display("FAIL setidle_count: got %0d expected 1", bus.Count); end
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL setidle_access: got %0b expected 0", bus.Access); end
    attempt(2'd2, 12'h0BB, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL setidle_pw_kept: got %0b expected 1", bus.Access); end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    attempt(2'd3, 12'h0CC, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL tmo_open: got %0b expected 1", bus.Access); end
    bad = 0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      if (bus.Access !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_held: early-low cycles got %0d expected 0", bad); end
    @(negedge clk);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL tmo_drop: got %0b expected 0", bus.Access); end
    // Enter held high for five edges counts once.
    bus.User = 2'd0;
    bus.InputPassword = 12'h123;
    bus.SET_MODE = 1'b0;
    bus.Enter = 1'b1;
    repeat (5) @(negedge clk);
    bus.Enter = 1'b0;
    $display("txn user=0 pw=123 set=0 held=5 -> Access=%0b Alarm=%0b Count=%0d", bus.Access, bus.Alarm, bus.Count);
    checks++; if (bus.Count !== 2'd1) begin errors++; $display("FAIL hold_one_attempt: got %0d expected 1", bus.Count); end
  endtask

  task automatic test_independent();
    do_reset();
    attempt(2'd0, 12'h111, 1'b0);
    attempt(2'd0, 12'h222, 1'b0);
    attempt(2'd1, 12'h333, 1'b0);
    attempt(2'd1, 12'h444, 1'b0);
    checks++; if (bus.Count !== 2'd2) begin errors++; $display("FAIL indep_u1: got %0d expected 2", bus.Count); end
    checks++; if (bus.Alarm !== 1'b0) begin errors++; $display("FAIL indep_alarm: got %0b expected 0", bus.Alarm); end
    bus.User = 2'd0;
    #1;
    checks++; if (bus.Count !== 2'd2) begin errors++; $display("FAIL indep_u0: got %0d expected 2", bus.Count); end
    // Reprogram user 2, then reset in the middle of a session.
    attempt(2'd2, 12'h0BB, 1'b0);
    attempt(2'd2, 12'h111, 1'b1);
    attempt(2'd2, 12'h111, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL midrst_open: got %0b expected 1", bus.Access); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL midrst_access: got %0b expected 0", bus.Access); end
    reset = 1'b0;
    bus.User = 2'd0;
    #1;
    checks++; if (bus.Count !== 2'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.Count); end
    attempt(2'd2, 12'h0BB, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL midrst_default_pw: got %0b expected 1", bus.Access); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    attempt(2'd1, 12'h0AA, 1'b0);
    attempt(2'd3, 12'h0CC, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL b2b_reopen: got %0b expected 1", bus.Access); end
    attempt(2'd1, 12'h999, 1'b1);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL b2b_foreign_set: got %0b expected 0", bus.Access); end
    checks++; if (bus.Count !== 2'd1) begin errors++; $display("FAIL b2b_foreign_count: got %0d expected 1", bus.Count); end
    attempt(2'd1, 12'h0AA, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL b2b_pw_kept: got %0b expected 1", bus.Access); end
  endtask

  task automatic test_lockout();
    int bad;
    do_reset();
    attempt(2'd0, 12'h001, 1'b0);
    attempt(2'd0, 12'h002, 1'b0);
    attempt(2'd0, 12'h003, 1'b0);
    checks++; if (bus.Alarm !== 1'b1) begin errors++; $display("FAIL lock_enter: got %0b expected 1", bus.Alarm); end
`ifdef LOCKER_LOCKOUT_TIMER_EN
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (bus.Alarm !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lock_held: early-clear cycles got %0d expected 0", bad); end
    @(negedge clk);
    checks++; if (bus.Alarm !== 1'b0) begin errors++; $display("FAIL lock_release: got %0b expected 0", bus.Alarm); end
    checks++; if (bus.Count !== 2'd0) begin errors++; $display("FAIL lock_count_clr: got %0d expected 0", bus.Count); end
    attempt(2'd0, 12'h000, 1'b0);
    checks++; if (bus.Access !== 1'b1) begin errors++; $display("FAIL lock_then_open: got %0b expected 1", bus.Access); end
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.Alarm !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL latch_held: clear cycles got %0d expected 0", bad); end
    attempt(2'd0, 12'h000, 1'b0);
    checks++; if (bus.Access !== 1'b0) begin errors++; $display("FAIL latch_ignore: got %0b expected 0", bus.Access); end
    checks++; if (bus.Count !== 2'd3) begin errors++; $display("FAIL latch_count: got %0d expected 3", bus.Count); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.Enter = 1'b0;
    bus.SET_MODE = 1'b0;
    bus.User = '0;
    bus.InputPassword = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_alarm();
    test_program();
    test_set_no_session();
    test_timeout();
    test_independent();
    test_back_to_back();
    test_lockout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
